// File: rtl/uart_rx_2byte.sv
// Two-byte UART receiver: oversampled 8N1 bytes reassembled into a 16-bit word
// (first byte in [7:0]), with a bounded idle gap allowed between the two bytes.
module uart_rx_2byte #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned GAP_BITS   = 4
) (
  input  logic        clk_153k6hz,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] data,
  output logic        valid,
  output logic        err,
  output logic        busy
);

  localparam int unsigned GAP_LIMIT = GAP_BITS * OVERSAMPLE;
  localparam int unsigned MAX_TICK  = (GAP_LIMIT > OVERSAMPLE) ? GAP_LIMIT : OVERSAMPLE;
  localparam int unsigned CW        = $clog2(MAX_TICK + 1);

  localparam logic [CW-1:0] T_HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T_BIT  = CW'(OVERSAMPLE);
  localparam logic [CW-1:0] T_GAP  = CW'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rxs_q, rxs_prev_q;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          byte_idx_q, byte_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall;

  assign fall = rxs_prev_q & ~rxs_q;

  // tick is 1 on the cycle after each reference point (E or a sample), so a
  // sample fires when tick equals the distance from that reference point.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + CW'(1);
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    sh_d       = sh_q;
    byte0_d    = byte0_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = tick_q;
        if (fall) begin
          state_d    = START;
          tick_d     = CW'(1);
          byte_idx_d = 1'b0;
        end
      end
      START: begin
        if (tick_q == T_HALF) begin
          tick_d  = CW'(1);
          bit_d   = 3'd0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == T_BIT) begin
          sh_d   = {rxs_q, sh_q[7:1]};
          tick_d = CW'(1);
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == T_BIT) begin
          tick_d = CW'(1);
          if (!rxs_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (!byte_idx_q) begin
            byte0_d = sh_q;
            state_d = GAP;
          end else begin
            data_d  = {sh_q, byte0_q};
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (fall) begin
          state_d    = START;
          tick_d     = CW'(1);
          byte_idx_d = 1'b1;
        end else if (tick_q == T_GAP) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_153k6hz or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      byte_idx_q <= 1'b0;
      sh_q       <= '0;
      byte0_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      sh_q       <= sh_d;
      byte0_q    <= byte0_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_2byte.sv
// Directed bench for uart_rx_2byte: nominal, glitch, framing error, gap timeout,
// mid-frame reset and back-to-back frames at 16 cycles per bit.
module tb_uart_rx_2byte;

  localparam int unsigned OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] data;
  logic        valid, err, busy;

  int unsigned checks = 0;
  int unsigned failures = 0;

  int unsigned cyc = 0;
  int unsigned valid_cnt = 0, err_cnt = 0;
  int unsigned valid_cyc = 0, err_cyc = 0;
  int unsigned both_hi = 0;
  logic [15:0] vq[$];

  uart_rx_2byte #(.OVERSAMPLE(OS), .GAP_BITS(4)) dut (
    .clk_153k6hz(clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      vq.push_back(data);
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (valid && err) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stopb);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned c0, vc, ec;
    logic [7:0] b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Nominal 0xA55A, zero gap: E0 = c0+2, byte-1 E = c0+162, stop sample c0+314.
    c0 = cyc;
    send_word(16'hA55A);
    idle(20);
    check("nom_valid_cnt", valid_cnt, 1);
    check("nom_data", 32'(data), 32'hA55A);
    check("nom_valid_cyc", valid_cyc, c0 + 315);
    check("nom_err_cnt", err_cnt, 0);
    check("nom_busy", 32'(busy), 32'h0);

    // Glitch: 4 cycles low, start sample sees high again.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch_valid_cnt", valid_cnt, 1);
    check("glitch_err_cnt", err_cnt, 0);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_data", 32'(data), 32'hA55A);

    // Framing error: stop sample at c0+154, err visible one cycle later.
    c0 = cyc;
    send_byte(8'h3C, 1'b0);
    idle(20);
    check("ferr_err_cnt", err_cnt, 1);
    check("ferr_err_cyc", err_cyc, c0 + 155);
    check("ferr_valid_cnt", valid_cnt, 1);
    check("ferr_data", 32'(data), 32'hA55A);
    send_word(16'h1234);
    idle(20);
    check("after_ferr_valid_cnt", valid_cnt, 2);
    check("after_ferr_data", 32'(data), 32'h1234);

    // Gap timeout: stop sample at c0+154, err 64 cycles later.
    c0 = cyc;
    send_byte(8'hFF, 1'b1);
    idle(80);
    check("gap_err_cnt", err_cnt, 2);
    check("gap_err_cyc", err_cyc, c0 + 218);
    check("gap_valid_cnt", valid_cnt, 2);
    check("gap_data", 32'(data), 32'h1234);

    // Three-bit-period gap stays inside the window.
    send_byte(8'hFF, 1'b1);
    idle(3 * OS);
    send_byte(8'h81, 1'b1);
    idle(20);
    check("gap3_valid_cnt", valid_cnt, 3);
    check("gap3_data", 32'(data), 32'h81FF);
    check("gap3_err_cnt", err_cnt, 2);

    // Reset asserted halfway through bit 4 of byte 1.
    vc = valid_cnt;
    ec = err_cnt;
    send_byte(8'h77, 1'b1);
    b1 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b1[i]);
    rx = b1[4];
    repeat (OS / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(40);
    check("rst_no_pulse", valid_cnt + err_cnt, vc + ec);
    send_word(16'hBEEF);
    idle(20);
    check("beef_valid_cnt", valid_cnt, vc + 1);
    check("beef_data", 32'(data), 32'hBEEF);

    // Back-to-back frames with no idle between them.
    vq.delete();
    vc = valid_cnt;
    send_word(16'h0001);
    send_word(16'h8000);
    send_word(16'hFFFF);
    idle(20);
    check("b2b_valid_cnt", valid_cnt, vc + 3);
    check("b2b_q_size", vq.size(), 3);
    if (vq.size() == 3) begin
      check("b2b_word0", 32'(vq[0]), 32'h0001);
      check("b2b_word1", 32'(vq[1]), 32'h8000);
      check("b2b_word2", 32'(vq[2]), 32'hFFFF);
    end
    check("b2b_err_cnt", err_cnt, ec);
    check("valid_err_exclusive", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
